// File: rtl/btn_sel_ctrl_pkg.sv
// Shared types and constants for the push-button select path.
package btn_pkg;

  localparam int unsigned NUM_BTN = 3;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Short debounce window used by simulation benches.
  localparam int unsigned DEBOUNCE_SIM = 4;

endpackage

// File: rtl/btn_sel_ctrl_if.sv
// Button-side bus: raw buttons in, debounced level, press pulses and select out.
interface btn_sel_ctrl_if;
  import btn_pkg::*;

  btn_vec_t btn;
  btn_vec_t sel;
  btn_vec_t press;
  btn_vec_t btn_level;

  modport master (output btn, input sel, input press, input btn_level);
  modport slave  (input btn, output sel, output press, output btn_level);

endinterface

// File: rtl/btn_sel_ctrl_debounce.sv
// One-bit 2-FF synchronizer followed by a counter debouncer holding the stable level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = btn_i;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any return to the stable level restarts the window; the count never passes the limit.
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/btn_sel_ctrl.sv
// Debounced push-buttons to registered LED select bus.
// BTN_SEL_ONEHOT_EN: a press loads a one-hot select (highest index wins) instead of toggling.
module btn_sel_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  btn_sel_ctrl_if.slave  bus
);

  btn_vec_t level;
  btn_vec_t level_dly_q, level_dly_d;
  btn_vec_t press_q, press_d;
  btn_vec_t sel_q, sel_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.btn[i]),
      .level_o (level[i])
    );
  end

  always_comb begin
    level_dly_d = level;
    press_d     = level & ~level_dly_q;
    sel_d       = sel_q;
`ifdef BTN_SEL_ONEHOT_EN
    // Ascending scan so the highest-index simultaneous press overrides lower ones.
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (press_d[i]) sel_d = btn_vec_t'(1) << i;
    end
`else
    sel_d = sel_q ^ press_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_dly_q <= '0;
      press_q     <= '0;
      sel_q       <= '0;
    end else begin
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      sel_q       <= sel_d;
    end
  end

  assign bus.btn_level = level;
  assign bus.press     = press_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Directed self-checking bench for btn_sel_ctrl with a 4-cycle debounce window.
module tb_btn_sel_ctrl;
  import btn_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned press2_cnt;

  btn_sel_ctrl_if bus ();

  btn_sel_ctrl #(
    .DEBOUNCE_CYCLES(DEBOUNCE_SIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.press[2] === 1'b1) press2_cnt++;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.btn = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_state", {bus.btn_level, bus.press, bus.sel}, 32'h0);
  endtask

  // Hold btn=v for n cycles from a settled-low level; with window 4 the level
  // rises after the 6th edge and press/sel after the 7th.
  task automatic run_press(input string tag, input btn_vec_t v, input int unsigned n,
                           input btn_vec_t sel_before, input btn_vec_t sel_after);
    btn_vec_t lv, pv, sv;
    bus.btn = v;
    for (int unsigned c = 1; c <= n; c++) begin
      tick();
      lv = (c >= 6) ? v : '0;
      pv = (c == 7) ? v : '0;
      sv = (c >= 7) ? sel_after : sel_before;
      check_eq($sformatf("%s_c%0d", tag, c), {bus.btn_level, bus.press, bus.sel}, {lv, pv, sv});
    end
  endtask

  task automatic run_release(input string tag, input int unsigned n,
                             input btn_vec_t lvl_before, input btn_vec_t sel_exp);
    btn_vec_t lv;
    bus.btn = '0;
    for (int unsigned c = 1; c <= n; c++) begin
      tick();
      lv = (c >= 6) ? btn_vec_t'(0) : lvl_before;
      check_eq($sformatf("%s_c%0d", tag, c), {bus.btn_level, bus.press, bus.sel}, {lv, 3'b000, sel_exp});
    end
  endtask

  btn_vec_t exp_simul, exp_seq2, exp_seq3, exp_dt1, exp_dt2;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    press2_cnt = 0;
    rst        = 1'b1;
    bus.btn    = '0;
`ifdef BTN_SEL_ONEHOT_EN
    exp_simul = 3'b100;
    exp_seq2  = 3'b100;
    exp_seq3  = 3'b100;
    exp_dt1   = 3'b100;
    exp_dt2   = 3'b100;
`else
    exp_simul = 3'b101;
    exp_seq2  = 3'b101;
    exp_seq3  = 3'b001;
    exp_dt1   = 3'b101;
    exp_dt2   = 3'b001;
`endif

    do_reset();

    // Clean press of button 0, held 20 cycles, then release.
    run_press("clean", 3'b001, 20, 3'b000, 3'b001);
    run_release("clean_rel", 12, 3'b001, 3'b001);

    // Bounce on button 1 shorter than the window.
    for (int unsigned p = 0; p < 4; p++) begin
      bus.btn = (p % 2 == 0) ? 3'b010 : 3'b000;
      for (int unsigned c = 0; c < 2; c++) begin
        tick();
        check_eq($sformatf("bounce_p%0d_c%0d", p, c), {bus.btn_level, bus.press, bus.sel}, {3'b000, 3'b000, 3'b001});
      end
    end
    bus.btn = '0;
    for (int unsigned c = 0; c < 10; c++) begin
      tick();
      check_eq($sformatf("bounce_tail_c%0d", c), {bus.btn_level, bus.press, bus.sel}, {3'b000, 3'b000, 3'b001});
    end

    // Two full press/release cycles on button 2.
    press2_cnt = 0;
    run_press("dt1", 3'b100, 10, 3'b001, exp_dt1);
    run_release("dt1_rel", 10, 3'b100, exp_dt1);
    run_press("dt2", 3'b100, 10, exp_dt1, exp_dt2);
    run_release("dt2_rel", 10, 3'b100, exp_dt2);
    check_eq("dt_press2_count", press2_cnt, 32'd2);

    // Simultaneous presses of buttons 0 and 2.
    do_reset();
    run_press("simul", 3'b101, 10, 3'b000, exp_simul);
    run_release("simul_rel", 10, 3'b101, exp_simul);

    // Reset in the middle of a debounce window with the button still held.
    do_reset();
    bus.btn = 3'b001;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_cleared", {bus.btn_level, bus.press, bus.sel}, 32'h0);
    run_press("midrst", 3'b001, 10, 3'b000, 3'b001);
    run_release("midrst_rel", 10, 3'b001, 3'b001);

    // Sequence btn0, btn2, btn2.
    do_reset();
    run_press("seq1", 3'b001, 10, 3'b000, 3'b001);
    run_release("seq1_rel", 10, 3'b001, 3'b001);
    run_press("seq2", 3'b100, 10, 3'b001, exp_seq2);
    run_release("seq2_rel", 10, 3'b100, exp_seq2);
    run_press("seq3", 3'b100, 10, exp_seq2, exp_seq3);
    run_release("seq3_rel", 10, 3'b100, exp_seq3);
    check_eq("seq_final_sel", bus.sel, exp_seq3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
